// File: rtl/plab4_net_router_input_buf_sep.sv
// Router input buffer with two independent per-domain circular queues.
// Each domain has private storage, pointers and count; no bypass from empty.
module plab4_net_router_input_buf_sep #(
  parameter int p_num_routers = 8,
  parameter int p_msg_nbits   = 44,
  parameter int p_dest_lsb    = 34,
  parameter int p_num_entries = 4,
  localparam int c_dest_nbits = $clog2(p_num_routers),
  localparam int c_cnt_nbits  = $clog2(p_num_entries) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_val,
  output logic                    in_rdy,
  input  logic [p_msg_nbits-1:0]  in_msg,
  input  logic                    in_domain,
  output logic                    out_val_d1,
  output logic                    out_val_d2,
  input  logic                    out_rdy_d1,
  input  logic                    out_rdy_d2,
  output logic [p_msg_nbits-1:0]  out_msg_d1,
  output logic [p_msg_nbits-1:0]  out_msg_d2,
  output logic [c_dest_nbits-1:0] dest_d1,
  output logic [c_dest_nbits-1:0] dest_d2,
  output logic [c_cnt_nbits-1:0]  num_free_d1,
  output logic [c_cnt_nbits-1:0]  num_free_d2
);

  localparam int c_ptr_nbits = $clog2(p_num_entries);
  localparam logic [c_cnt_nbits-1:0] c_entries = c_cnt_nbits'(p_num_entries);

  logic [1:0]                        full;
  logic [1:0]                        oval;
  logic [1:0]                        ordy;
  logic [1:0][p_msg_nbits-1:0]       omsg;
  logic [1:0][c_cnt_nbits-1:0]       nfree;

  assign ordy = {out_rdy_d2, out_rdy_d1};

  // Reset overrides acceptance so the reset cycle always looks empty.
  assign in_rdy = reset | (in_domain ? !full[1] : !full[0]);

  for (genvar d = 0; d < 2; d++) begin : g_dom
    logic [p_msg_nbits-1:0] mem_q [p_num_entries];
    logic [c_ptr_nbits-1:0] wptr_q, wptr_d;
    logic [c_ptr_nbits-1:0] rptr_q, rptr_d;
    logic [c_cnt_nbits-1:0] cnt_q, cnt_d;
    logic                   enq;
    logic                   deq;

    assign enq = in_val && in_rdy && !reset && (in_domain == 1'(d));
    assign deq = oval[d] && ordy[d];

    assign full[d]  = (cnt_q == c_entries);
    assign oval[d]  = !reset && (cnt_q != '0);
    assign omsg[d]  = oval[d] ? mem_q[rptr_q] : '0;
    assign nfree[d] = reset ? c_entries : c_entries - cnt_q;

    always_comb begin
      wptr_d = enq ? wptr_q + c_ptr_nbits'(1) : wptr_q;
      rptr_d = deq ? rptr_q + c_ptr_nbits'(1) : rptr_q;
      cnt_d  = cnt_q;
      unique case (1'b1)
        enq && !deq: cnt_d = cnt_q + c_cnt_nbits'(1);
        deq && !enq: cnt_d = cnt_q - c_cnt_nbits'(1);
        default:     cnt_d = cnt_q;
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
      end else begin
        wptr_q <= wptr_d;
        rptr_q <= rptr_d;
        cnt_q  <= cnt_d;
      end
    end

    always_ff @(posedge clk) begin
      if (enq) mem_q[wptr_q] <= in_msg;
    end
  end

  assign out_val_d1  = oval[0];
  assign out_val_d2  = oval[1];
  assign out_msg_d1  = omsg[0];
  assign out_msg_d2  = omsg[1];
  assign dest_d1     = omsg[0][p_dest_lsb +: c_dest_nbits];
  assign dest_d2     = omsg[1][p_dest_lsb +: c_dest_nbits];
  assign num_free_d1 = nfree[0];
  assign num_free_d2 = nfree[1];

endmodule

// File: tb/tb_plab4_net_router_input_buf_sep.sv
// Bench for the split-domain router input buffer.
// Reference model: two plain queues of depth 4.
module tb_plab4_net_router_input_buf_sep;

  typedef logic [43:0] msg_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_val;
  logic       in_rdy;
  msg_t       in_msg;
  logic       in_domain;
  logic       out_val_d1, out_val_d2;
  logic       out_rdy_d1, out_rdy_d2;
  msg_t       out_msg_d1, out_msg_d2;
  logic [2:0] dest_d1, dest_d2;
  logic [2:0] num_free_d1, num_free_d2;

  plab4_net_router_input_buf_sep dut (
    .clk(clk), .reset(reset),
    .in_val(in_val), .in_rdy(in_rdy),
    .in_msg(in_msg), .in_domain(in_domain),
    .out_val_d1(out_val_d1), .out_val_d2(out_val_d2),
    .out_rdy_d1(out_rdy_d1), .out_rdy_d2(out_rdy_d2),
    .out_msg_d1(out_msg_d1), .out_msg_d2(out_msg_d2),
    .dest_d1(dest_d1), .dest_d2(dest_d2),
    .num_free_d1(num_free_d1), .num_free_d2(num_free_d2)
  );

  always #5 clk = ~clk;

  int   nvec = 0;
  int   nerr = 0;
  msg_t q1[$];
  msg_t q2[$];
  msg_t popped[$];
  logic last_rdy;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cycle(input logic rs, input logic iv, input logic dom,
                       input msg_t m, input logic r1, input logic r2);
    logic ov1, ov2, rdy;
    msg_t e1, e2;
    reset = rs; in_val = iv; in_domain = dom; in_msg = m;
    out_rdy_d1 = r1; out_rdy_d2 = r2;
    #1;
    ov1 = !rs && q1.size() != 0;
    ov2 = !rs && q2.size() != 0;
    e1  = ov1 ? q1[0] : '0;
    e2  = ov2 ? q2[0] : '0;
    rdy = rs ? 1'b1 : (dom ? q2.size() < 4 : q1.size() < 4);
    chk("in_rdy", in_rdy, rdy);
    chk("val_d1", out_val_d1, ov1);
    chk("val_d2", out_val_d2, ov2);
    chk("msg_d1", out_msg_d1, e1);
    chk("msg_d2", out_msg_d2, e2);
    chk("dest_d1", dest_d1, e1[34+:3]);
    chk("dest_d2", dest_d2, e2[34+:3]);
    chk("free_d1", num_free_d1, rs ? 4 : 4 - q1.size());
    chk("free_d2", num_free_d2, rs ? 4 : 4 - q2.size());
    last_rdy = in_rdy;
    if (ov2 && r2) popped.push_back(out_msg_d2);
    @(posedge clk);
    if (rs) begin
      q1.delete();
      q2.delete();
    end else begin
      if (ov1 && r1) void'(q1.pop_front());
      if (ov2 && r2) void'(q2.pop_front());
      if (iv && rdy) begin
        if (dom) q2.push_back(m);
        else     q1.push_back(m);
      end
    end
    #1;
  endtask

  function automatic msg_t rmsg();
    return msg_t'({$urandom, $urandom});
  endfunction

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, rmsg(), 1'b0, 1'b0);
  endtask

  task automatic rst();
    cycle(1'b1, 1'b0, 1'b0, rmsg(), 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; in_val = 1'b0; in_domain = 1'b0; in_msg = '0;
    out_rdy_d1 = 1'b0; out_rdy_d2 = 1'b0;
    @(posedge clk); #1;
    rst();
    idle();

    // single message to D1 with dest 3
    cycle(1'b0, 1'b1, 1'b0, msg_t'(44'd3 << 34) | 44'h5a, 1'b0, 1'b0);
    chk("r036_val1", out_val_d1, 1);
    chk("r036_dest", dest_d1, 3);
    chk("r036_val2", out_val_d2, 0);
    chk("r036_free", num_free_d1, 3);

    // fill D1 and check D2 still accepts
    rst();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, rmsg(), 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, rmsg(), 1'b0, 1'b0);
    chk("r037_rdy_d1", last_rdy, 0);
    cycle(1'b0, 1'b1, 1'b1, rmsg(), 1'b0, 1'b0);
    chk("r037_rdy_d2", last_rdy, 1);
    chk("r037_free1", num_free_d1, 0);
    chk("r037_free2", num_free_d2, 3);

    // full D1 with simultaneous dequeue: no pass-through
    cycle(1'b0, 1'b1, 1'b0, rmsg(), 1'b1, 1'b0);
    chk("r038_rdy", last_rdy, 0);
    chk("r038_free", num_free_d1, 1);
    cycle(1'b0, 1'b0, 1'b0, rmsg(), 1'b0, 1'b0);
    chk("r038_rdy2", last_rdy, 1);

    // wrap-around stream through D2
    rst();
    popped.delete();
    for (int i = 0; i < 10; i++)
      cycle(1'b0, 1'b1, 1'b1, msg_t'(i), 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk("r039_cnt", popped.size(), 10);
    for (int i = 0; i < popped.size() && i < 10; i++)
      chk("r039_ord", popped[i], i);

    // simultaneous enq/deq
    rst();
    cycle(1'b0, 1'b1, 1'b0, rmsg(), 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, rmsg(), 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, rmsg(), 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, rmsg(), 1'b1, 1'b0);
    chk("r040_same", num_free_d1, 2);
    cycle(1'b0, 1'b1, 1'b1, rmsg(), 1'b1, 1'b1);
    chk("r040_f1", num_free_d1, 3);
    chk("r040_f2", num_free_d2, 3);

    // reset mid-stream discards everything
    cycle(1'b0, 1'b1, 1'b1, rmsg(), 1'b0, 1'b0);
    rst();
    chk("r041_f1", num_free_d1, 4);
    chk("r041_f2", num_free_d2, 4);
    chk("r041_v1", out_val_d1, 0);
    chk("r041_v2", out_val_d2, 0);
    chk("r041_m1", out_msg_d1, 0);
    chk("r041_m2", out_msg_d2, 0);
    for (int i = 0; i < 3; i++) idle();

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      cycle($urandom_range(0, 63) == 0,
            $urandom_range(0, 9) < 7,
            1'($urandom),
            rmsg(),
            1'($urandom),
            $urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
